// File: rtl/btn_debouncer_multi_pkg.sv
// Shared constants and types for the multi-channel button debouncer.
// Defaults are derived from the 50 MHz board clock:
//   stability window 20 cycles, repeat delay 0.5 s, repeat period 0.1 s.
package btn_debouncer_multi_pkg;

  localparam int CLK_HZ            = 50_000_000;
  localparam int DEF_STABLE_CYCLES = 20;
  localparam int DEF_REPEAT_DELAY  = CLK_HZ / 2;   // 0.5 s
  localparam int DEF_REPEAT_PERIOD = CLK_HZ / 10;  // 0.1 s

  typedef enum logic [1:0] {
    RPT_IDLE  = 2'd0,
    RPT_DELAY = 2'd1,
    RPT_RUN   = 2'd2
  } rpt_state_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Width able to hold 0..n-1; never below 1 bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/btn_debouncer_multi_if.sv
// Button bundle between the board pins and the game-control logic.
//   btn_in      : raw asynchronous inputs, bit i = channel i
//   btn_level   : debounced level
//   btn_press   : 1-cycle pulse on debounced 0->1
//   btn_release : 1-cycle pulse on debounced 1->0
//   btn_repeat  : 1-cycle auto-repeat pulses while held
// master = the side driving the pins (board / bench), slave = the debouncer.
interface btn_debouncer_multi_if #(
  parameter int NUM_CH = 5
);
  logic [NUM_CH-1:0] btn_in;
  logic [NUM_CH-1:0] btn_level;
  logic [NUM_CH-1:0] btn_press;
  logic [NUM_CH-1:0] btn_release;
  logic [NUM_CH-1:0] btn_repeat;

  modport master (
    output btn_in,
    input  btn_level, btn_press, btn_release, btn_repeat
  );

  modport slave (
    input  btn_in,
    output btn_level, btn_press, btn_release, btn_repeat
  );
endinterface

// File: rtl/btn_debouncer_multi_ch.sv
// One debouncer channel: 2-flop synchroniser, stability filter, registered
// press/release pulses and an optional hold-to-repeat FSM.
// Ports:
//   clk_50m, rst_n (async active low)
//   btn_in      : raw pin
//   btn_level   : debounced level
//   btn_press   : pulse with the first cycle of level=1
//   btn_release : pulse with the first cycle of level=0
//   btn_repeat  : auto-repeat pulses (tied 0 when REPEAT_EN=0)
module btn_debounce_ch
  import btn_debouncer_multi_pkg::*;
#(
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int REPEAT_EN     = 0,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic clk_50m,
  input  logic rst_n,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_repeat
);

  localparam int              CNT_W   = cnt_width(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(STABLE_CYCLES - 1);

  logic             s1_q, s1_d, s2_q, s2_d;
  logic             cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;

  // Any disagreement with the candidate restarts the window; once the window
  // is full the counter saturates and the candidate is committed (once).
  always_comb begin
    s1_d      = btn_in;
    s2_d      = s1_q;
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (s2_q != cand_q) begin
      cand_d = s2_q;
      cnt_d  = '0;
    end else if (cnt_q == CNT_TOP) begin
      if (cand_q != level_q) begin
        level_d   = cand_q;
        press_d   = cand_q;
        release_d = ~cand_q;
      end
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      cand_q    <= 1'b0;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;

  generate
    if (REPEAT_EN != 0) begin : g_rpt
      localparam int               RPT_W   = cnt_width(max2(REPEAT_DELAY, REPEAT_PERIOD));
      localparam logic [RPT_W-1:0] DLY_TOP = RPT_W'(REPEAT_DELAY - 1);
      localparam logic [RPT_W-1:0] PER_TOP = RPT_W'(REPEAT_PERIOD - 1);

      rpt_state_e       st_q, st_d;
      logic [RPT_W-1:0] rcnt_q, rcnt_d;
      logic             rpt_q, rpt_d;

      // Keyed off the same-cycle press/release decisions so the FSM moves on
      // the edge that registers the pulse; release wins and silences repeats.
      always_comb begin
        st_d   = st_q;
        rcnt_d = rcnt_q;
        rpt_d  = 1'b0;
        if (release_d) begin
          st_d   = RPT_IDLE;
          rcnt_d = '0;
        end else if (press_d) begin
          st_d   = RPT_DELAY;
          rcnt_d = '0;
        end else begin
          case (st_q)
            RPT_DELAY: begin
              if (rcnt_q == DLY_TOP) begin
                rpt_d  = 1'b1;
                st_d   = RPT_RUN;
                rcnt_d = '0;
              end else begin
                rcnt_d = rcnt_q + 1'b1;
              end
            end
            RPT_RUN: begin
              if (rcnt_q == PER_TOP) begin
                rpt_d  = 1'b1;
                rcnt_d = '0;
              end else begin
                rcnt_d = rcnt_q + 1'b1;
              end
            end
            default: begin
              st_d   = RPT_IDLE;
              rcnt_d = '0;
            end
          endcase
        end
      end

      always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
          st_q   <= RPT_IDLE;
          rcnt_q <= '0;
          rpt_q  <= 1'b0;
        end else begin
          st_q   <= st_d;
          rcnt_q <= rcnt_d;
          rpt_q  <= rpt_d;
        end
      end

      assign btn_repeat = rpt_q;
    end else begin : g_no_rpt
      assign btn_repeat = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/btn_debouncer_multi.sv
// N-channel push-button / switch debouncer in the clk_50m domain.
// Ports:
//   clk_50m : 50 MHz system clock
//   rst_n   : asynchronous active-low reset
//   bus     : slave side of btn_debouncer_multi_if (raw in, debounced out)
// Channels are fully independent; each is one btn_debounce_ch instance.
module btn_debouncer_multi
  import btn_debouncer_multi_pkg::*;
#(
  parameter int NUM_CH        = 5,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int REPEAT_EN     = 0,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic                  clk_50m,
  input  logic                  rst_n,
  btn_debouncer_multi_if.slave  bus
);

  generate
    if (NUM_CH < 1) begin : g_bad_nch
      $error("btn_debouncer_multi: NUM_CH must be >= 1");
    end
    if (STABLE_CYCLES < 2) begin : g_bad_stable
      $error("btn_debouncer_multi: STABLE_CYCLES must be >= 2");
    end
    if (REPEAT_EN != 0 && REPEAT_DELAY < 1) begin : g_bad_dly
      $error("btn_debouncer_multi: REPEAT_DELAY must be >= 1");
    end
    if (REPEAT_EN != 0 && REPEAT_PERIOD < 1) begin : g_bad_per
      $error("btn_debouncer_multi: REPEAT_PERIOD must be >= 1");
    end
  endgenerate

  logic [NUM_CH-1:0] level_w, press_w, release_w, repeat_w;

  generate
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      btn_debounce_ch #(
        .STABLE_CYCLES (STABLE_CYCLES),
        .REPEAT_EN     (REPEAT_EN),
        .REPEAT_DELAY  (REPEAT_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD)
      ) u_ch (
        .clk_50m     (clk_50m),
        .rst_n       (rst_n),
        .btn_in      (bus.btn_in[g]),
        .btn_level   (level_w[g]),
        .btn_press   (press_w[g]),
        .btn_release (release_w[g]),
        .btn_repeat  (repeat_w[g])
      );
    end
  endgenerate

  assign bus.btn_level   = level_w;
  assign bus.btn_press   = press_w;
  assign bus.btn_release = release_w;
  assign bus.btn_repeat  = repeat_w;

endmodule

// File: tb/tb_btn_debouncer_multi.sv
// Directed bench: NUM_CH=2, STABLE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
// Inputs change 1 ns after a rising edge; with cyc = index of that edge, a
// clean change is seen on btn_level at edge cyc+7.
module tb_btn_debouncer_multi;

  localparam int NCH = 2;

  logic clk_50m = 1'b0;
  logic rst_n   = 1'b0;
  always #5 clk_50m = ~clk_50m;

  btn_debouncer_multi_if #(.NUM_CH(NCH)) bus ();

  btn_debouncer_multi #(
    .NUM_CH        (NCH),
    .STABLE_CYCLES (4),
    .REPEAT_EN     (1),
    .REPEAT_DELAY  (10),
    .REPEAT_PERIOD (3)
  ) dut (
    .clk_50m (clk_50m),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  int cyc = 0;
  always @(posedge clk_50m) cyc <= cyc + 1;

  // Pulse monitor, sampled mid-cycle.
  int press_cnt [NCH];
  int rel_cnt   [NCH];
  int rpt0 [$];
  int rpt1 [$];
  always @(negedge clk_50m) begin
    for (int i = 0; i < NCH; i++) begin
      if (bus.btn_press[i])   press_cnt[i] <= press_cnt[i] + 1;
      if (bus.btn_release[i]) rel_cnt[i]   <= rel_cnt[i] + 1;
    end
    if (bus.btn_repeat[0]) rpt0.push_back(cyc);
    if (bus.btn_repeat[1]) rpt1.push_back(cyc);
  end

  int n_run  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_50m);
    #1;
  endtask

  int p, r, last, b0, b1, pc0, pc1, rc0, rc1;

  initial begin
    bus.btn_in = '0;
    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_level",   32'(bus.btn_level),   0);
    chk("rst_press",   32'(bus.btn_press),   0);
    chk("rst_release", 32'(bus.btn_release), 0);
    chk("rst_repeat",  32'(bus.btn_repeat),  0);
    rst_n = 1'b1;
    repeat (3) tick();

    // Clean press on ch0, release so the release pulse lands at press+14.
    b0 = rpt0.size(); pc0 = press_cnt[0]; rc0 = rel_cnt[0];
    bus.btn_in[0] = 1'b1;
    repeat (6) tick();
    chk("clean_lvl_early", 32'(bus.btn_level[0]), 0);
    tick();
    chk("clean_lvl",       32'(bus.btn_level[0]), 1);
    chk("clean_press",     32'(bus.btn_press[0]), 1);
    chk("clean_no_rel",    32'(bus.btn_release[0]), 0);
    p = cyc;
    tick();
    chk("clean_press_1cyc", 32'(bus.btn_press[0]), 0);
    repeat (6) tick();
    bus.btn_in[0] = 1'b0;
    repeat (7) tick();
    chk("rel_pulse",   32'(bus.btn_release[0]), 1);
    chk("rel_lvl",     32'(bus.btn_level[0]), 0);
    chk("rel_no_prs",  32'(bus.btn_press[0]), 0);
    repeat (10) tick();
    chk("rpt_count",   32'(rpt0.size() - b0), 2);
    chk("rpt_first",   32'(rpt0[b0] - p), 10);
    chk("rpt_second",  32'(rpt0[b0+1] - p), 13);
    chk("clean_npress", 32'(press_cnt[0] - pc0), 1);
    chk("clean_nrel",   32'(rel_cnt[0] - rc0), 1);

    // Glitch of 4 cycles: rejected.
    b0 = rpt0.size(); pc0 = press_cnt[0]; rc0 = rel_cnt[0];
    bus.btn_in[0] = 1'b1;
    repeat (4) tick();
    bus.btn_in[0] = 1'b0;
    repeat (15) tick();
    chk("g4_npress", 32'(press_cnt[0] - pc0), 0);
    chk("g4_nrel",   32'(rel_cnt[0] - rc0), 0);
    chk("g4_lvl",    32'(bus.btn_level[0]), 0);

    // Glitch of 5 cycles: accepted, one press and one release.
    bus.btn_in[0] = 1'b1;
    repeat (5) tick();
    bus.btn_in[0] = 1'b0;
    repeat (30) tick();
    chk("g5_npress", 32'(press_cnt[0] - pc0), 1);
    chk("g5_nrel",   32'(rel_cnt[0] - rc0), 1);
    chk("g5_lvl",    32'(bus.btn_level[0]), 0);
    chk("g5_nrpt",   32'(rpt0.size() - b0), 0);

    // Bounce on ch1: 15 toggles every 2 cycles, ends high.
    pc1 = press_cnt[1]; rc1 = rel_cnt[1]; pc0 = press_cnt[0];
    last = 0;
    for (int k = 0; k < 15; k++) begin
      bus.btn_in[1] = ~bus.btn_in[1];
      last = cyc;
      tick();
      tick();
    end
    repeat (4) tick();
    chk("bnc_lvl_early", 32'(bus.btn_level[1]), 0);
    tick();
    chk("bnc_press_at7", 32'(bus.btn_press[1]), 1);
    chk("bnc_press_cyc", 32'(cyc - last), 7);
    repeat (3) tick();
    chk("bnc_npress", 32'(press_cnt[1] - pc1), 1);
    chk("bnc_nrel",   32'(rel_cnt[1] - rc1), 0);
    chk("bnc_ch0_quiet", 32'(press_cnt[0] - pc0), 0);
    bus.btn_in[1] = 1'b0;
    repeat (12) tick();

    // Reset while ch0 sits in DELAY, input still high through release.
    bus.btn_in[0] = 1'b1;
    repeat (7) tick();
    chk("rst_pre_press", 32'(bus.btn_press[0]), 1);
    repeat (4) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_lvl", 32'(bus.btn_level[0]), 0);
    chk("rst_async_all", 32'({bus.btn_level, bus.btn_press, bus.btn_release, bus.btn_repeat}), 0);
    b0 = rpt0.size();
    tick();
    tick();
    rst_n = 1'b1;
    r = cyc;
    repeat (6) tick();
    chk("rst_lvl_early", 32'(bus.btn_level[0]), 0);
    tick();
    chk("rst_rel_press", 32'(bus.btn_press[0]), 1);
    chk("rst_rel_lvl",   32'(bus.btn_level[0]), 1);
    repeat (12) tick();
    chk("rst_rpt_count", 32'(rpt0.size() - b0), 1);
    chk("rst_rpt_first", 32'(rpt0[b0] - r), 17);
    bus.btn_in[0] = 1'b0;
    repeat (12) tick();

    // Independence: both pressed together, ch1 released early.
    b0 = rpt0.size(); b1 = rpt1.size(); rc0 = rel_cnt[0]; rc1 = rel_cnt[1];
    bus.btn_in = 2'b11;
    repeat (7) tick();
    chk("ind_press", 32'(bus.btn_press), 3);
    p = cyc;
    repeat (5) tick();
    bus.btn_in[1] = 1'b0;
    repeat (25) tick();
    chk("ind_rpt0_count", 32'(rpt0.size() - b0), 7);
    chk("ind_rpt0_first", 32'(rpt0[b0] - p), 10);
    chk("ind_rpt0_last",  32'(rpt0[b0+6] - p), 28);
    chk("ind_rpt1_count", 32'(rpt1.size() - b1), 1);
    chk("ind_nrel1",      32'(rel_cnt[1] - rc1), 1);
    chk("ind_nrel0",      32'(rel_cnt[0] - rc0), 0);
    chk("ind_lvl",        32'(bus.btn_level), 1);
    bus.btn_in = '0;
    repeat (12) tick();
    chk("end_lvl", 32'(bus.btn_level), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
